// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcode constants and the datapath control codes inherited from the
// single-cycle decoder, plus the decoded-instruction bundles.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_LUI   = 5'd1;
  localparam logic [4:0] ALU_AUIPC = 5'd2;
  localparam logic [4:0] ALU_ADD   = 5'd3;
  localparam logic [4:0] ALU_SUB   = 5'd4;
  localparam logic [4:0] ALU_BNE   = 5'd5;
  localparam logic [4:0] ALU_BLT   = 5'd6;
  localparam logic [4:0] ALU_BGE   = 5'd7;
  localparam logic [4:0] ALU_BLTU  = 5'd8;
  localparam logic [4:0] ALU_BGEU  = 5'd9;
  localparam logic [4:0] ALU_SLT   = 5'd10;
  localparam logic [4:0] ALU_SLTU  = 5'd11;
  localparam logic [4:0] ALU_XOR   = 5'd12;
  localparam logic [4:0] ALU_OR    = 5'd13;
  localparam logic [4:0] ALU_AND   = 5'd14;
  localparam logic [4:0] ALU_SLL   = 5'd15;
  localparam logic [4:0] ALU_SRL   = 5'd16;
  localparam logic [4:0] ALU_SRA   = 5'd17;

  // One-hot immediate type: {shamt, I, S, B, U, J}
  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  // {jalr, jal, branch-taken}
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [2:0] DM_WORD  = 3'd0;
  localparam logic [2:0] DM_HALF  = 3'd1;
  localparam logic [2:0] DM_HALFU = 3'd2;
  localparam logic [2:0] DM_BYTE  = 3'd3;
  localparam logic [2:0] DM_BYTEU = 3'd4;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // Instruction class; all-zero for anything the decoder does not recognise.
  typedef struct packed {
    logic legal;
    logic is_wb;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
  } dec_class_t;

  // Static datapath controls, constant for the life of one instruction.
  typedef struct packed {
    logic [4:0] alu_op;
    logic [5:0] ext_op;
    logic       alu_src;
    logic [2:0] dm_type;
    logic [1:0] wd_sel;
  } dec_ctrl_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational RV32I decoder: instruction word -> class flags and the
// static datapath controls. Unrecognised opcode/funct combinations come
// out as an all-zero class and all-zero controls.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_class_t  cls,
  output dec_ctrl_t   ctl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;
  dec_class_t c;
  dec_ctrl_t  k;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // Register specifiers are consumed by the datapath, not by control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Opcode/funct decode; an illegal combination squashes everything to zero.
  always_comb begin
    c = '0;
    k = '0;
    case (opcode)
      OP_R: begin
        c.legal = 1'b1;
        c.is_wb = 1'b1;
        k.wd_sel = WD_ALU;
        case ({f7, f3})
          {7'h00, 3'd0}: k.alu_op = ALU_ADD;
          {7'h20, 3'd0}: k.alu_op = ALU_SUB;
          {7'h00, 3'd1}: k.alu_op = ALU_SLL;
          {7'h00, 3'd2}: k.alu_op = ALU_SLT;
          {7'h00, 3'd3}: k.alu_op = ALU_SLTU;
          {7'h00, 3'd4}: k.alu_op = ALU_XOR;
          {7'h00, 3'd5}: k.alu_op = ALU_SRL;
          {7'h20, 3'd5}: k.alu_op = ALU_SRA;
          {7'h00, 3'd6}: k.alu_op = ALU_OR;
          {7'h00, 3'd7}: k.alu_op = ALU_AND;
          default:       c.legal = 1'b0;
        endcase
      end
      OP_I: begin
        c.legal = 1'b1;
        c.is_wb = 1'b1;
        k.alu_src = 1'b1;
        k.ext_op = EXT_I;
        k.wd_sel = WD_ALU;
        case (f3)
          3'd0: k.alu_op = ALU_ADD;
          3'd2: k.alu_op = ALU_SLT;
          3'd3: k.alu_op = ALU_SLTU;
          3'd4: k.alu_op = ALU_XOR;
          3'd6: k.alu_op = ALU_OR;
          3'd7: k.alu_op = ALU_AND;
          3'd1: begin
            k.ext_op = EXT_SHAMT;
            k.alu_op = ALU_SLL;
            if (f7 != 7'h00) c.legal = 1'b0;
          end
          default: begin
            k.ext_op = EXT_SHAMT;
            if (f7 == 7'h00)      k.alu_op = ALU_SRL;
            else if (f7 == 7'h20) k.alu_op = ALU_SRA;
            else                  c.legal = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        c.legal = 1'b1;
        c.is_load = 1'b1;
        k.alu_src = 1'b1;
        k.ext_op = EXT_I;
        k.alu_op = ALU_ADD;
        k.wd_sel = WD_MEM;
        case (f3)
          3'd0:    k.dm_type = DM_BYTE;
          3'd1:    k.dm_type = DM_HALF;
          3'd2:    k.dm_type = DM_WORD;
          3'd4:    k.dm_type = DM_BYTEU;
          3'd5:    k.dm_type = DM_HALFU;
          default: c.legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        c.legal = 1'b1;
        c.is_store = 1'b1;
        k.alu_src = 1'b1;
        k.ext_op = EXT_S;
        k.alu_op = ALU_ADD;
        case (f3)
          3'd0:    k.dm_type = DM_BYTE;
          3'd1:    k.dm_type = DM_HALF;
          3'd2:    k.dm_type = DM_WORD;
          default: c.legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        c.legal = 1'b1;
        c.is_branch = 1'b1;
        k.ext_op = EXT_B;
        case (f3)
          3'd0:    k.alu_op = ALU_SUB;
          3'd1:    k.alu_op = ALU_BNE;
          3'd4:    k.alu_op = ALU_BLT;
          3'd5:    k.alu_op = ALU_BGE;
          3'd6:    k.alu_op = ALU_BLTU;
          3'd7:    k.alu_op = ALU_BGEU;
          default: c.legal = 1'b0;
        endcase
      end
      OP_LUI: begin
        c.legal = 1'b1;
        c.is_wb = 1'b1;
        k.alu_src = 1'b1;
        k.ext_op = EXT_U;
        k.alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        c.legal = 1'b1;
        c.is_wb = 1'b1;
        k.alu_src = 1'b1;
        k.ext_op = EXT_U;
        k.alu_op = ALU_AUIPC;
      end
      OP_JAL: begin
        c.legal = 1'b1;
        c.is_wb = 1'b1;
        c.is_jal = 1'b1;
        k.ext_op = EXT_J;
        k.wd_sel = WD_PC;
      end
      OP_JALR: begin
        c.legal = (f3 == 3'd0);
        c.is_wb = 1'b1;
        c.is_jalr = 1'b1;
        k.alu_src = 1'b1;
        k.ext_op = EXT_I;
        k.alu_op = ALU_ADD;
        k.wd_sel = WD_PC;
      end
      default: c = '0;
    endcase
    if (!c.legal) begin
      c = '0;
      k = '0;
    end
  end

  assign cls = c;
  assign ctl = k;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit: FSM sequencing, retired-instruction
// counter, memory wait-state timeout and per-state gating of the datapath
// controls. Optional macro MC_CTRL_ILLEGAL_TRAP_EN adds a sticky `illegal`
// output and halts on unrecognised instructions instead of treating them
// as NOPs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | imem_req high, waiting for imem_ready; IRWrite on ready
// S_DECODE | IR valid, static controls presented, no write enables
// S_EXEC   | ALU step; branches and NOPs retire here
// S_MEM    | dmem_req high, waiting for dmem_ready; stores retire here
// S_WB     | register writeback, PC update, retire
// S_HALT   | memory timeout (or illegal trap); absorbing until reset
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      instr,
  input  logic             Zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [5:0]       EXTOp,
  output logic [4:0]       ALUOp,
  output logic [2:0]       NPCOp,
  output logic             ALUSrc,
  output logic [2:0]       DMType,
  output logic [1:0]       WDSel,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret,
  output logic             bus_err
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  logic [CNT_W-1:0]  instret_q;
  logic              bus_err_q;
  logic              wait_hit, wait_inc, wait_clr, retire, err_set, show_ctl;
  logic              ireq_r, dreq_r, irw_r, pcw_r, rw_r, mw_r;
  logic [2:0]        npc_r;
  dec_class_t        cls;
  dec_ctrl_t         ctl;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic              illegal_q, ill_set;
`endif

  mc_ctrl_dec u_dec (
    .instr (instr),
    .cls   (cls),
    .ctl   (ctl)
  );

  assign wait_nxt = wait_q + WAIT_W'(1);
  assign wait_hit = (wait_nxt == WAIT_LIM);

  // State register, wait counter, retire counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_nxt;
      if (retire)  instret_q <= instret_q + CNT_W'(1);
      if (err_set) bus_err_q <= 1'b1;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag.
  always_ff @(posedge clk) begin
    if (!rstn)        illegal_q <= 1'b0;
    else if (ill_set) illegal_q <= 1'b1;
  end
`endif

  // Next-state logic and raw per-state strobes.
  always_comb begin
    state_d  = state_q;
    wait_inc = 1'b0;
    retire   = 1'b0;
    err_set  = 1'b0;
    show_ctl = 1'b0;
    ireq_r   = 1'b0;
    dreq_r   = 1'b0;
    irw_r    = 1'b0;
    pcw_r    = 1'b0;
    rw_r     = 1'b0;
    mw_r     = 1'b0;
    npc_r    = NPC_PLUS4;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ill_set  = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        ireq_r = 1'b1;
        if (imem_ready) begin
          irw_r   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        show_ctl = 1'b1;
        state_d  = S_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (!cls.legal) begin
          ill_set = 1'b1;
          state_d = S_HALT;
        end
`endif
      end
      S_EXEC: begin
        show_ctl = 1'b1;
        if (cls.is_branch) begin
          npc_r   = {2'b00, Zero};
          pcw_r   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (cls.is_load || cls.is_store) begin
          state_d = S_MEM;
        end else if (cls.legal && cls.is_wb) begin
          state_d = S_WB;
        end else begin
          // Unrecognised instruction retires as a NOP.
          pcw_r   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        show_ctl = 1'b1;
        dreq_r   = 1'b1;
        mw_r     = cls.is_store;
        if (dmem_ready) begin
          if (cls.is_store) begin
            pcw_r   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        show_ctl = 1'b1;
        rw_r     = 1'b1;
        pcw_r    = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        if (cls.is_jal)       npc_r = NPC_JUMP;
        else if (cls.is_jalr) npc_r = NPC_JALR;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // The wait counter restarts whenever a new access phase begins.
  always_comb begin
    wait_clr = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
  end

  // Everything is forced low while reset is held so an in-flight access drops at once.
  assign imem_req = rstn & ireq_r;
  assign dmem_req = rstn & dreq_r;
  assign IRWrite  = rstn & irw_r;
  assign PCWrite  = rstn & pcw_r;
  assign RegWrite = rstn & rw_r;
  assign MemWrite = rstn & mw_r;
  assign NPCOp    = rstn ? npc_r : 3'b000;
  assign ALUOp    = (rstn && show_ctl) ? ctl.alu_op  : 5'd0;
  assign EXTOp    = (rstn && show_ctl) ? ctl.ext_op  : 6'd0;
  assign ALUSrc   = rstn & show_ctl & ctl.alu_src;
  assign DMType   = (rstn && show_ctl) ? ctl.dm_type : 3'd0;
  assign WDSel    = (rstn && show_ctl) ? ctl.wd_sel  : 2'd0;
  assign state_o  = rstn ? state_q : 3'd0;
  assign instret  = rstn ? instret_q : '0;
  assign bus_err  = rstn & bus_err_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal  = rstn & illegal_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (MAX_WAIT=4): add, lw with wait states,
// taken/not-taken beq, sw, jal, unrecognised opcode, reset mid-access and
// instruction-fetch timeout.
module tb_mc_ctrl;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;
  // enable vector = {IRWrite, PCWrite, RegWrite, MemWrite, imem_req, dmem_req}
  localparam logic [5:0] IR = 6'b100000, PC = 6'b010000, RW = 6'b001000;
  localparam logic [5:0] MW = 6'b000100, IQ = 6'b000010, DQ = 6'b000001;
  localparam logic [5:0] NONE = 6'b000000;

  logic        clk, rstn, Zero, imem_ready, dmem_ready;
  logic [31:0] instr;
  logic        imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite;
  logic [5:0]  EXTOp;
  logic [4:0]  ALUOp;
  logic [2:0]  NPCOp, DMType, state_o;
  logic        ALUSrc, bus_err;
  logic [1:0]  WDSel;
  logic [31:0] instret;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks = 0;
  int failures = 0;
  int exp_ir;

  mc_ctrl #(.CNT_W(32), .WAIT_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrc(ALUSrc),
    .DMType(DMType), .WDSel(WDSel), .state_o(state_o),
    .instret(instret), .bus_err(bus_err)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [2:0] st, input logic [5:0] en);
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_en"}, 32'({IRWrite, PCWrite, RegWrite, MemWrite, imem_req, dmem_req}), 32'(en));
  endtask

  initial begin
    rstn = 1'b0; instr = 32'h0; Zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    look("rst", F, NONE);
    chk("rst_instret", instret, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    // add x3,x1,x2
    instr = 32'h002081B3; imem_ready = 1'b1;
    look("add_f", F, IR | IQ); chk("add_instret0", instret, 0);
    @(negedge clk); imem_ready = 1'b0;
    look("add_d", D, NONE); chk("add_aluop", 32'(ALUOp), 3); chk("add_alusrc", 32'(ALUSrc), 0);
    @(negedge clk);
    look("add_e", E, NONE);
    @(negedge clk);
    look("add_wb", W, RW | PC); chk("add_wdsel", 32'(WDSel), 0); chk("add_aluop_wb", 32'(ALUOp), 3);
    @(negedge clk);

    // lw x5,0(x1) with dmem_ready three cycles late
    instr = 32'h0000A283; imem_ready = 1'b1;
    look("lw_f", F, IR | IQ); chk("add_instret1", instret, 1);
    @(negedge clk); imem_ready = 1'b0;
    look("lw_d", D, NONE);
    chk("lw_extop", 32'(EXTOp), 32'h10); chk("lw_alusrc", 32'(ALUSrc), 1); chk("lw_aluop", 32'(ALUOp), 3);
    @(negedge clk);
    look("lw_e", E, NONE);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      look("lw_m_wait", M, DQ);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    look("lw_m_rdy", M, DQ);
    @(negedge clk); dmem_ready = 1'b0;
    look("lw_wb", W, RW | PC); chk("lw_wdsel", 32'(WDSel), 1); chk("lw_dmtype", 32'(DMType), 0);
    @(negedge clk);

    // beq x0,x0 taken then not taken
    instr = 32'h00000063; imem_ready = 1'b1;
    look("beq1_f", F, IR | IQ); chk("lw_instret2", instret, 2);
    @(negedge clk); imem_ready = 1'b0;
    look("beq1_d", D, NONE); chk("beq_aluop", 32'(ALUOp), 4); chk("beq_extop", 32'(EXTOp), 32'h04);
    @(negedge clk); Zero = 1'b1;
    look("beq1_e", E, PC); chk("beq1_npcop", 32'(NPCOp), 1);
    @(negedge clk); Zero = 1'b0; imem_ready = 1'b1;
    look("beq2_f", F, IR | IQ); chk("beq1_instret3", instret, 3);
    @(negedge clk); imem_ready = 1'b0;
    look("beq2_d", D, NONE);
    @(negedge clk);
    look("beq2_e", E, PC); chk("beq2_npcop", 32'(NPCOp), 0);
    @(negedge clk);

    // sw x2,0(x1)
    instr = 32'h0020A023; imem_ready = 1'b1;
    look("sw_f", F, IR | IQ); chk("beq2_instret4", instret, 4);
    @(negedge clk); imem_ready = 1'b0;
    look("sw_d", D, NONE); chk("sw_extop", 32'(EXTOp), 32'h08);
    @(negedge clk);
    look("sw_e", E, NONE);
    @(negedge clk); dmem_ready = 1'b1;
    look("sw_m", M, DQ | MW | PC);
    @(negedge clk); dmem_ready = 1'b0;

    // jal x1,0
    instr = 32'h000000EF; imem_ready = 1'b1;
    look("jal_f", F, IR | IQ); chk("sw_instret5", instret, 5);
    @(negedge clk); imem_ready = 1'b0;
    look("jal_d", D, NONE); chk("jal_extop", 32'(EXTOp), 32'h01);
    @(negedge clk);
    look("jal_e", E, NONE);
    @(negedge clk);
    look("jal_wb", W, RW | PC); chk("jal_npcop", 32'(NPCOp), 2); chk("jal_wdsel", 32'(WDSel), 2);
    @(negedge clk);

    // reset while a load waits in S_MEM
    instr = 32'h0000A283; imem_ready = 1'b1;
    look("rlw_f", F, IR | IQ); chk("jal_instret6", instret, 6);
    @(negedge clk); imem_ready = 1'b0;
    look("rlw_d", D, NONE);
    @(negedge clk);
    look("rlw_e", E, NONE);
    @(negedge clk);
    look("rlw_m", M, DQ);
    rstn = 1'b0;
    #1;
    chk("rlw_dreq_drop", 32'(dmem_req), 0);
    @(negedge clk); rstn = 1'b1;
    look("rlw_after", F, IQ); chk("rlw_instret", instret, 0);
    @(negedge clk);

    // opcode 0x7F: NOP by default, trap with the optional feature
    instr = 32'h0000007F; imem_ready = 1'b1;
    look("ill_f", F, IR | IQ);
    @(negedge clk); imem_ready = 1'b0;
    look("ill_d", D, NONE); chk("ill_aluop", 32'(ALUOp), 0);
    @(negedge clk);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    look("ill_halt", H, NONE); chk("ill_flag", 32'(illegal), 1); chk("ill_instret", instret, 0);
    @(negedge clk);
    look("ill_hold", H, NONE);
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    exp_ir = 0;
`else
    look("nop_e", E, PC);
    @(negedge clk);
    exp_ir = 1;
`endif

    // fetch timeout: imem_ready never arrives
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      look("to_wait", F, IQ); chk("to_bus_err0", 32'(bus_err), 0);
      @(negedge clk);
    end
    look("to_halt", H, NONE); chk("to_bus_err1", 32'(bus_err), 1); chk("to_instret", instret, 32'(exp_ir));
    @(negedge clk); imem_ready = 1'b1; dmem_ready = 1'b1;
    look("halt_hold1", H, NONE);
    @(negedge clk);
    look("halt_hold2", H, NONE); chk("halt_bus_err", 32'(bus_err), 1);
    rstn = 1'b0; dmem_ready = 1'b0;
    @(negedge clk); rstn = 1'b1;
    look("post_rst", F, IR | IQ); chk("post_rst_bus_err", 32'(bus_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit for the RV32I core: the FSM-sequenced successor to the single-cycle decoder. It sequences FETCH/DECODE/EXEC/MEM/WB over a latched instruction word and handshakes with instruction and data memories that may insert wait states. It emits the existing datapath control set (RegWrite, MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc, DMType, WDSel), qualified per state, plus PCWrite/IRWrite strobes. It also provides a retired-instruction counter and memory-timeout detection.

Parameters:
CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)
WAIT_W, 8, width of memory wait counter
MAX_WAIT, 255, cycles allowed between req and ready before timeout (must be < 2^WAIT_W)

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  synchronous active-low reset
instr  in  32  instruction word from IR (valid from DECODE onward)
Zero  in  1  branch condition result from ALU (valid in EXEC)
imem_ready  in  1  instruction memory ready, 1-cycle pulse or level
dmem_ready  in  1  data memory ready
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
IRWrite  out  1  latch instruction into IR
PCWrite  out  1  update PC with NPC
RegWrite  out  1  register file write enable
MemWrite  out  1  data memory write enable
EXTOp  out  6  immediate type (one-hot: shamt, I, S, B, U, J)
ALUOp  out  5  ALU operation code
NPCOp  out  3  next-PC select ({jalr, jal, branch-taken})
ALUSrc  out  1  ALU operand B = immediate
DMType  out  3  load/store width/sign type
WDSel  out  2  writeback select (00 ALU, 01 mem, 10 PC+4)
state_o  out  3  current FSM state (debug)
instret  out  CNT_W  retired instruction count
bus_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rstn=0 at posedge): state=S_FETCH, instret=0, bus_err=0, wait counter=0; all outputs combinationally 0 while rstn=0; reset mid-access abandons the access (req drops the same cycle).
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT.
- S_FETCH: imem_req=1; stay until imem_ready; on ready: IRWrite=1, go S_DECODE.
- S_DECODE: decode instr; ALUSrc/EXTOp/ALUOp presented; no write enables; always go S_EXEC.
- S_EXEC: ALU ops, lui, auipc, jal, jalr -> S_WB; loads/stores -> S_MEM; branches: NPCOp[0]=Zero, PCWrite=1, instret++, -> S_FETCH.
- S_MEM: dmem_req=1, MemWrite=1 for stores; wait for dmem_ready; store -> PCWrite=1, instret++, S_FETCH; load -> S_WB.
- S_WB: RegWrite=1 (rd=x0 still asserted; the register file ignores it), WDSel per type, NPCOp for jal/jalr, PCWrite=1, instret++, -> S_FETCH.
- Latency from fetch-ready to next fetch: branch 3, store 4, ALU/U/J 4, load 5 cycles, plus wait states.
- RegWrite, MemWrite, PCWrite, IRWrite are asserted only in the states named above; never otherwise.
- ALUOp/EXTOp/DMType/WDSel decoding matches the current single-cycle encodings (constants in ctrl_pkg), held stable from S_DECODE to instruction end.
- Wait counter: cleared on entering S_FETCH/S_MEM, increments each cycle req=1 and ready=0; reaching MAX_WAIT sets bus_err and goes to S_HALT.
- S_HALT: all enables 0, absorbing until reset.
- Ready sampled only while the corresponding req=1; stray ready is ignored.
- Unrecognised opcode without the feature: treated as NOP (S_EXEC -> PCWrite=1, instret++, S_FETCH).

Optional Feature:
MC_CTRL_ILLEGAL_TRAP_EN: adds output illegal (1 bit, sticky). Unrecognised opcode/funct combination in S_DECODE sets illegal, goes to S_HALT, no PCWrite, instret not incremented. Without the macro: port absent, NOP behaviour as above.

Decomposition:
- ctrl_pkg: opcode constants, state enum, ALUOp/EXTOp/NPCOp/DMType/WDSel encodings.
- Sub-module mc_ctrl_dec: combinational instr -> class flags plus static controls (reusable decode). mc_ctrl holds the FSM, counters and per-state gating.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ready immediate -> states F,D,E,WB; RegWrite=1 only in WB; instret 0->1; ALUOp=add code.
- lw with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles in S_MEM; WDSel=01 in WB; total 8 cycles fetch-to-fetch.
- beq with Zero=1 then Zero=0 -> NPCOp=001 vs 000 in EXEC; PCWrite=1 both; 3 cycles each; no RegWrite.
- sw (0x0020A023) -> MemWrite=1 only during S_MEM; no RegWrite; instret +1.
- imem_ready held 0 with MAX_WAIT=4 -> bus_err=1 after 4 cycles, state_o=S_HALT, all enables 0 until rstn=0.
- Assert rstn=0 mid-S_MEM -> next cycle state=S_FETCH, instret=0, dmem_req=0; with the trap macro, opcode 0x7F -> illegal=1, HALT.
